// File: rtl/lf_ed_autocal.sv
// Calibration sequencer for the LF edge detector: settle, measure the filtered
// ADC min/max over a fixed window, then derive and hold the edge threshold.
module lf_ed_autocal #(
  parameter int SETTLE_CYCLES  = 4096,
  parameter int WINDOW_SAMPLES = 256,
  parameter int THR_SHIFT      = 2,
  parameter int MIN_SPAN       = 8,
  parameter int THR_MIN        = 2
) (
  input  logic       pck0,
  input  logic       rst_n,
  input  logic [7:0] adc_d,
  input  logic       adc_rdy,
  input  logic       lf_field,
  input  logic       auto_enable,
  input  logic       cal_req,
  input  logic [7:0] manual_threshold,
  output logic [7:0] lf_ed_threshold,
  output logic       ed_enable,
  output logic       cal_busy,
  output logic       cal_fail,
  output logic [7:0] cal_min,
  output logic [7:0] cal_max
);
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int CW = $clog2(WINDOW_SAMPLES) + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WINDOW_SAMPLES - 1);
  localparam logic [8:0]    MIN_SPAN_L  = 9'(MIN_SPAN);
  localparam logic [7:0]    THR_MIN_L   = 8'(THR_MIN);
  localparam logic [7:0]    THR_MAX_L   = 8'd127;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPUTE, RUN} state_t;

  state_t        state_q, state_d;
  logic          field_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    run_min_q, run_min_d, run_max_q, run_max_d;
  logic [7:0]    thr_q, thr_d;
  logic          en_q, en_d, busy_q, busy_d, fail_q, fail_d;
  logic [7:0]    cmin_q, cmin_d, cmax_q, cmax_d;
  logic          field_rise, field_fall;
  logic [7:0]    span;

  function automatic logic [7:0] sat_thr(input logic [7:0] s);
    logic [7:0] shifted;
    shifted = s >> THR_SHIFT;
    if (shifted < THR_MIN_L) return THR_MIN_L;
    if (shifted > THR_MAX_L) return THR_MAX_L;
    return shifted;
  endfunction

  assign field_rise = lf_field & ~field_q;
  assign field_fall = ~lf_field & field_q;
  assign span       = run_max_q - run_min_q;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    thr_d     = thr_q;
    fail_d    = fail_q;
    cmin_d    = cmin_q;
    cmax_d    = cmax_q;
    if (!auto_enable) begin
      state_d = IDLE;
      thr_d   = manual_threshold;
    end else if (field_fall) begin
      // Field loss aborts anything in flight; results of the last window stay.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (field_rise || cal_req) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
            fail_d   = 1'b0;
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_d   = MEASURE;
            run_min_d = 8'hFF;
            run_max_d = 8'h00;
            cnt_d     = '0;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        MEASURE: begin
          if (adc_rdy) begin
            if (adc_d < run_min_q) run_min_d = adc_d;
            if (adc_d > run_max_q) run_max_d = adc_d;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == WIN_LAST) state_d = COMPUTE;
          end
        end
        COMPUTE: begin
          cmin_d  = run_min_q;
          cmax_d  = run_max_q;
          state_d = RUN;
          if ({1'b0, span} < MIN_SPAN_L) begin
            fail_d = 1'b1;
            thr_d  = manual_threshold;
          end else begin
            thr_d = sat_thr(span);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    en_d   = auto_enable ? (state_d == RUN) : lf_field;
    busy_d = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == COMPUTE);
  end

  always_ff @(posedge pck0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      field_q   <= 1'b0;
      settle_q  <= '0;
      cnt_q     <= '0;
      run_min_q <= 8'hFF;
      run_max_q <= 8'h00;
      thr_q     <= 8'd127;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
      cmin_q    <= 8'hFF;
      cmax_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      field_q   <= lf_field;
      settle_q  <= settle_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      thr_q     <= thr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
      cmin_q    <= cmin_d;
      cmax_q    <= cmax_d;
    end
  end

  assign lf_ed_threshold = thr_q;
  assign ed_enable       = en_q;
  assign cal_busy        = busy_q;
  assign cal_fail        = fail_q;
  assign cal_min         = cmin_q;
  assign cal_max         = cmax_q;
endmodule

// File: tb/tb_lf_ed_autocal.sv
// Bench for lf_ed_autocal: manual-mode vector table, directed calibration
// sequences and randomized windows checked against a window-level model.
`timescale 1ns/1ps
module tb_lf_ed_autocal;
  localparam int S = 16;
  localparam int W = 8;

  logic       pck0 = 1'b0;
  logic       rst_n, adc_rdy, lf_field, auto_enable, cal_req;
  logic [7:0] adc_d, manual_threshold;
  logic [7:0] thr, cmin, cmax, thr_s0, cmin_s0, cmax_s0, thr_m4, cmin_m4, cmax_m4;
  logic       en, busy, fail, en_s0, busy_s0, fail_s0, en_m4, busy_m4, fail_m4;

  int checks = 0;
  int failures = 0;
  int samp[W];
  int e_thr, e_min, e_max, e_fail;
  int e_thr_s0, e_fail_s0, e_thr_m4, e_fail_m4;

  typedef struct {
    logic       field;
    logic       req;
    logic [7:0] man;
    int         e_thr;
    int         e_en;
  } mvec_t;
  mvec_t tbl[5];

  always #5 pck0 = ~pck0;

  lf_ed_autocal #(.SETTLE_CYCLES(S), .WINDOW_SAMPLES(W), .THR_SHIFT(2), .MIN_SPAN(8), .THR_MIN(2)) dut (
    .pck0(pck0), .rst_n(rst_n), .adc_d(adc_d), .adc_rdy(adc_rdy), .lf_field(lf_field),
    .auto_enable(auto_enable), .cal_req(cal_req), .manual_threshold(manual_threshold),
    .lf_ed_threshold(thr), .ed_enable(en), .cal_busy(busy), .cal_fail(fail),
    .cal_min(cmin), .cal_max(cmax));

  lf_ed_autocal #(.SETTLE_CYCLES(S), .WINDOW_SAMPLES(W), .THR_SHIFT(0), .MIN_SPAN(8), .THR_MIN(2)) dut_s0 (
    .pck0(pck0), .rst_n(rst_n), .adc_d(adc_d), .adc_rdy(adc_rdy), .lf_field(lf_field),
    .auto_enable(auto_enable), .cal_req(cal_req), .manual_threshold(manual_threshold),
    .lf_ed_threshold(thr_s0), .ed_enable(en_s0), .cal_busy(busy_s0), .cal_fail(fail_s0),
    .cal_min(cmin_s0), .cal_max(cmax_s0));

  lf_ed_autocal #(.SETTLE_CYCLES(S), .WINDOW_SAMPLES(W), .THR_SHIFT(2), .MIN_SPAN(4), .THR_MIN(2)) dut_m4 (
    .pck0(pck0), .rst_n(rst_n), .adc_d(adc_d), .adc_rdy(adc_rdy), .lf_field(lf_field),
    .auto_enable(auto_enable), .cal_req(cal_req), .manual_threshold(manual_threshold),
    .lf_ed_threshold(thr_m4), .ed_enable(en_m4), .cal_busy(busy_m4), .cal_fail(fail_m4),
    .cal_min(cmin_m4), .cal_max(cmax_m4));

  task automatic tick();
    @(posedge pck0);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Threshold rule applied to a finished window.
  function automatic int thr_rule(input int span, input int shift, input int minspan, input int man);
    int t;
    if (span < minspan) return man;
    t = span >> shift;
    if (t < 2) t = 2;
    if (t > 127) t = 127;
    return t;
  endfunction

  task automatic set_alt(input int a, input int b);
    for (int i = 0; i < W; i++) samp[i] = (i % 2 == 0) ? a : b;
  endtask

  task automatic rand_samples();
    int lo, hi, wd;
    lo = int'($urandom_range(0, 255));
    wd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
    hi = (lo + wd > 255) ? 255 : lo + wd;
    for (int i = 0; i < W; i++) samp[i] = int'($urandom_range(hi, lo));
  endtask

  task automatic start_cal(input bit by_req);
    if (by_req) cal_req = 1'b1;
    else lf_field = 1'b1;
    tick();
    cal_req = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_en", en, 0);
    chk("start_fail", fail, 0);
    e_fail = 0; e_fail_s0 = 0; e_fail_m4 = 0;
  endtask

  task automatic run_window(input int gap, input bit req_mid, input int abort_at, input bit abort_strobe);
    int mn, mx, span, man;
    // Strobes with extreme values during settling must not enter the window.
    for (int c = 0; c < S + 2; c++) begin
      adc_rdy = (c < S / 2) && (c % 2 == 0);
      adc_d   = (c % 4 == 0) ? 8'd0 : 8'd255;
      tick();
      chk("settle_busy", busy, 1);
      chk("settle_en", en, 0);
    end
    adc_rdy = 1'b0;
    for (int i = 0; i < W; i++) begin
      adc_d = 8'(samp[i]);
      if (i == abort_at) begin
        lf_field = 1'b0;
        adc_rdy  = abort_strobe;
        tick();
        adc_rdy = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_en", en, 0);
        chk("abort_thr", thr, e_thr);
        chk("abort_min", cmin, e_min);
        chk("abort_max", cmax, e_max);
        chk("abort_fail", fail, e_fail);
        return;
      end
      adc_rdy = 1'b1;
      cal_req = req_mid && (i == 3);
      tick();
      adc_rdy = 1'b0;
      cal_req = 1'b0;
      chk("win_busy", busy, 1);
      chk("win_en", en, 0);
      if (i < W - 1) begin
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) begin
          tick();
          chk("gap_busy", busy, 1);
        end
      end
    end
    tick();
    mn = 255; mx = 0;
    for (int i = 0; i < W; i++) begin
      if (samp[i] < mn) mn = samp[i];
      if (samp[i] > mx) mx = samp[i];
    end
    span = mx - mn;
    man  = int'(manual_threshold);
    e_min = mn; e_max = mx;
    e_thr    = thr_rule(span, 2, 8, man); e_fail    = (span < 8) ? 1 : 0;
    e_thr_s0 = thr_rule(span, 0, 8, man); e_fail_s0 = (span < 8) ? 1 : 0;
    e_thr_m4 = thr_rule(span, 2, 4, man); e_fail_m4 = (span < 4) ? 1 : 0;
    chk("run_en", en, 1);
    chk("run_busy", busy, 0);
    chk("run_thr", thr, e_thr);
    chk("run_min", cmin, e_min);
    chk("run_max", cmax, e_max);
    chk("run_fail", fail, e_fail);
    chk("run_thr_s0", thr_s0, e_thr_s0);
    chk("run_fail_s0", fail_s0, e_fail_s0);
    chk("run_thr_m4", thr_m4, e_thr_m4);
    chk("run_fail_m4", fail_m4, e_fail_m4);
  endtask

  initial begin
    rst_n = 1'b1; adc_rdy = 1'b0; adc_d = 8'd0; lf_field = 1'b0;
    auto_enable = 1'b0; cal_req = 1'b0; manual_threshold = 8'd0;
    tbl[0] = '{1'b1, 1'b0, 8'd30,  30,  1};
    tbl[1] = '{1'b0, 1'b0, 8'd77,  77,  0};
    tbl[2] = '{1'b1, 1'b1, 8'd200, 200, 1};
    tbl[3] = '{1'b1, 1'b0, 8'd0,   0,   1};
    tbl[4] = '{1'b0, 1'b1, 8'd255, 255, 0};

    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_thr", thr, 127);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    chk("rst_min", cmin, 8'hFF);
    chk("rst_max", cmax, 8'h00);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      lf_field = tbl[v].field; cal_req = tbl[v].req; manual_threshold = tbl[v].man;
      tick();
      chk("man_thr", thr, tbl[v].e_thr);
      chk("man_en", en, tbl[v].e_en);
      chk("man_busy", busy, 0);
    end
    for (int r = 0; r < 16; r++) begin
      lf_field = 1'($urandom_range(0, 1));
      cal_req  = 1'($urandom_range(0, 1));
      adc_rdy  = 1'($urandom_range(0, 1));
      adc_d    = 8'($urandom_range(0, 255));
      manual_threshold = 8'($urandom_range(0, 255));
      tick();
      chk("rman_thr", thr, manual_threshold);
      chk("rman_en", en, lf_field);
      chk("rman_busy", busy, 0);
      chk("rman_fail", fail, 0);
    end
    cal_req = 1'b0; adc_rdy = 1'b0; lf_field = 1'b0; manual_threshold = 8'd45;
    tick();
    auto_enable = 1'b1;
    tick();
    chk("idle_en", en, 0);
    chk("idle_busy", busy, 0);

    set_alt(100, 180); start_cal(1'b0); run_window(3, 1'b0, -1, 1'b0);
    chk("a_thr_20", thr, 20);
    set_alt(128, 128); start_cal(1'b1); run_window(3, 1'b0, -1, 1'b0);
    chk("b_fail", fail, 1);
    chk("b_thr_45", thr, 45);
    set_alt(0, 255); start_cal(1'b1); run_window(3, 1'b1, -1, 1'b0);
    chk("c_thr_s0_clamp", thr_s0, 127);
    manual_threshold = 8'd99;
    set_alt(50, 55); start_cal(1'b1); run_window(-1, 1'b0, -1, 1'b0);
    chk("d_thr_m4_floor", thr_m4, 2);

    auto_enable = 1'b0; manual_threshold = 8'd12;
    tick();
    chk("off_fail_held", fail, 1);
    chk("off_thr", thr, 12);
    chk("off_en", en, 1);
    chk("off_busy", busy, 0);
    lf_field = 1'b0;
    tick();
    chk("off_en0", en, 0);
    lf_field = 1'b1; manual_threshold = 8'd60;
    tick();
    auto_enable = 1'b1;
    tick();
    chk("reauto_en", en, 0);
    chk("reauto_thr", thr, 60);
    e_thr = 60; e_thr_s0 = 60; e_thr_m4 = 60;

    rand_samples(); start_cal(1'b1); run_window(3, 1'b0, 5, 1'b0);
    tick();
    chk("abort_stay_idle", busy, 0);
    rand_samples(); start_cal(1'b0); run_window(-1, 1'b0, -1, 1'b0);

    cal_req = 1'b1; lf_field = 1'b0;
    tick();
    cal_req = 1'b0;
    chk("fallreq_busy", busy, 0);
    chk("fallreq_en", en, 0);
    chk("fallreq_thr", thr, e_thr);
    tick();
    chk("fallreq_idle", busy, 0);

    rand_samples(); start_cal(1'b0); run_window(3, 1'b0, 7, 1'b1);

    rand_samples(); start_cal(1'b0); run_window(-1, 1'b0, -1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      manual_threshold = 8'($urandom_range(0, 255));
      rand_samples();
      start_cal(1'b1);
      run_window(-1, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
